// File: rtl/counter_monitor.sv
// Watches an external up/down counter and flags any step it should not take.
// Tracks lock state, counts mismatches and clean wraps with saturation.
module counter_monitor #(
  parameter int N_WIDTH   = 4,
  parameter int UPbarDOWN = 1,
  parameter int ERR_W     = 8,
  parameter int WRAP_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               incr,
  input  logic [N_WIDTH-1:0] y,
  input  logic               resync,
  output logic               locked,
  output logic               error,
  output logic               fault,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [WRAP_W-1:0]  wrap_cnt
);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [N_WIDTH-1:0] ONE = N_WIDTH'(1);
  localparam logic [N_WIDTH-1:0] WRAP_FROM =
    (UPbarDOWN != 0) ? {N_WIDTH{1'b1}} : {N_WIDTH{1'b0}};
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

  state_t             state;
  state_t             state_next;
  logic [N_WIDTH-1:0] prev_y;
  logic               prev_incr;
  logic [N_WIDTH-1:0] exp_y;
  logic               check;
  logic               mismatch;
  logic               wrap_hit;

  always_comb begin
    exp_y = prev_y;
    if (prev_incr) begin
      exp_y = (UPbarDOWN != 0) ? prev_y + ONE : prev_y - ONE;
    end
  end

  // resync wins over any check at the same edge
  assign check    = (state == TRACK) && !resync;
  assign mismatch = check && (y != exp_y);
  assign wrap_hit = check && !mismatch && prev_incr
                  && (prev_y == WRAP_FROM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= UNSYNC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (resync) begin
      state_next = UNSYNC;
    end else begin
      unique case (state)
        UNSYNC:  state_next = TRACK;
        TRACK:   state_next = mismatch ? FAULT : TRACK;
        FAULT:   state_next = FAULT;
        default: state_next = UNSYNC;
      endcase
    end
  end

  always_comb begin
    locked = (state == TRACK);
    fault  = (state == FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_y    <= '0;
      prev_incr <= 1'b0;
      error     <= 1'b0;
      err_cnt   <= '0;
      wrap_cnt  <= '0;
    end else begin
      prev_y    <= y;
      prev_incr <= incr;
      error     <= mismatch;
      if (mismatch && err_cnt != ERR_MAX) begin
        err_cnt <= err_cnt + 1'b1;
      end
      if (wrap_hit && wrap_cnt != WRAP_MAX) begin
        wrap_cnt <= wrap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 The block SHALL have parameter N_WIDTH, default 4, giving the width of the observed count.
REQ-002 The block SHALL have parameter UPbarDOWN, default 1; 1 means the observed counter counts up and 0 means it counts down.
REQ-003 The block SHALL have parameter ERR_W, default 8, giving the error-counter width.
REQ-004 The block SHALL have parameter WRAP_W, default 16, giving the wrap-counter width.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with ports listed clock and reset first:
 clk  in  1  single clock; all state changes on its rising edge
 reset  in  1  asynchronous, active-high reset
 incr  in  1  enable driven to the observed counter
 y  in  N_WIDTH  observed counter output
 resync  in  1  synchronous request to return to UNSYNC
 locked  out  1  high while in TRACK
 error  out  1  one-cycle pulse on a detected mismatch
 fault  out  1  high while in FAULT (sticky)
 err_cnt  out  ERR_W  mismatches since reset, saturating
 wrap_cnt  out  WRAP_W  correct wraps since reset, saturating

Function
REQ-006 The block SHALL register y and incr every cycle as prev_y and prev_incr.
REQ-007 The block SHALL define exp as prev_y+1 mod 2^N_WIDTH when prev_incr=1 and UPbarDOWN=1, as prev_y-1 mod 2^N_WIDTH when prev_incr=1 and UPbarDOWN=0, and as prev_y when prev_incr=0.
REQ-008 The block SHALL implement a state machine with states UNSYNC, TRACK and FAULT; the reset state SHALL be UNSYNC.
REQ-009 In UNSYNC, at the next edge the block SHALL capture prev_y and prev_incr and move to TRACK without checking.
REQ-010 In TRACK, at each edge y≠exp SHALL pulse error high for exactly one cycle, increment err_cnt and move to FAULT.
REQ-011 In TRACK, at each edge y==exp SHALL keep the state at TRACK.
REQ-012 In TRACK, a check SHALL be a correct wrap when prev_incr=1, y==exp and prev_y==all-ones (UPbarDOWN=1) or prev_y==0 (UPbarDOWN=0); each correct wrap SHALL increment wrap_cnt.
REQ-013 In FAULT, the block SHALL perform no checks, produce no further error pulses and make no wrap_cnt increments.
REQ-014 resync=1 at an edge SHALL move the state to UNSYNC from any state and take priority over any check at that edge; it SHALL NOT clear err_cnt or wrap_cnt.
REQ-015 Outputs SHALL be registered and decoded from state: locked=(state==TRACK) and fault=(state==FAULT).
REQ-016 Mismatch detection latency SHALL be 1 cycle: error SHALL be high in the cycle after the edge at which the bad y is sampled.
REQ-017 err_cnt and wrap_cnt SHALL saturate at all-ones and never wrap back to 0.
REQ-018 Holding incr=0 in TRACK SHALL require y to stay constant; any change of y SHALL be a mismatch.

Reset
REQ-019 Asserting reset SHALL immediately set state=UNSYNC and clear locked, error, fault, err_cnt, wrap_cnt, prev_y and prev_incr, independent of clk.
REQ-020 Asserting reset in the middle of tracking SHALL discard history, and the first edge after deassertion SHALL behave as UNSYNC (no check).
REQ-021 While reset is high, all outputs SHALL remain 0.

Verification
REQ-022 Scenario: N_WIDTH=4, UPbarDOWN=1, incr=1, y stepping 0,1,..,15,0 from reset release -> locked=1 from the second edge, error never 1, wrap_cnt=1 after the 15→0 step.
REQ-023 Scenario: in TRACK, force y=5 where exp=4 -> error high for one cycle, err_cnt=1, fault=1, locked=0; later mismatches leave err_cnt=1.
REQ-024 Scenario: in FAULT, pulse resync for one cycle, then drive a correct sequence -> UNSYNC then TRACK, locked=1, err_cnt still 1.
REQ-025 Scenario: UPbarDOWN=0, y stepping 2,1,0,15 with incr=1 -> wrap_cnt=1, no error; with incr=0 and y held at 7 for 10 cycles -> no error, wrap_cnt unchanged.
REQ-026 Scenario: ERR_W=2, four mismatch-plus-resync cycles -> err_cnt saturates at 3.
REQ-027 Scenario: assert reset asynchronously mid-sequence, between clk edges -> all outputs 0 immediately; after release, the first edge performs no check.
